// File: rtl/coupling_avst_pkt_rx.sv
// rtl/coupling_avst_pkt_rx.sv - store-and-forward Avalon-ST packet receive buffer with framing checks
// Optional statistics counters are enabled by defining COUPLING_PKT_RX_STATS_EN.
module coupling_avst_pkt_rx #(
    parameter int DATA_W  = 32,
    parameter int CH_W    = 16,
    parameter int DEPTH   = 512,
    parameter int MAX_PKT = 4096
) (
    input  logic              clk_dsp_clk,
    input  logic              reset_dsp_reset,
    input  logic              snk_valid,
    input  logic [DATA_W-1:0] snk_data,
    input  logic [CH_W-1:0]   snk_channel,
    input  logic              snk_startofpacket,
    input  logic              snk_endofpacket,
    output logic              src_valid,
    input  logic              src_ready,
    output logic [DATA_W-1:0] src_data,
    output logic [CH_W-1:0]   src_channel,
    output logic              src_startofpacket,
    output logic              src_endofpacket,
    input  logic              count_clear,
    output logic [31:0]       pkt_count,
    output logic [15:0]       drop_count,
    output logic [15:0]       err_count,
    output logic              overflow_irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = DATA_W + CH_W + 2;
    localparam int LW = $clog2(MAX_PKT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   cmt_ptr_q, cmt_ptr_d;
    logic [PW-1:0]   cmt_vis_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [LW-1:0]   len_q, len_d;
    logic [EW-1:0]   mem [DEPTH];
    logic            we;
    logic [AW-1:0]   waddr;
    logic [EW-1:0]   wdata;
    logic            full_wr, full_cmt;
    logic            inc_pkt, inc_drop, inc_err;
    logic            irq_q;

    assign wdata    = {snk_endofpacket, snk_startofpacket, snk_channel, snk_data};
    assign full_wr  = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    assign full_cmt = (cmt_ptr_q - rd_ptr_q) == PW'(DEPTH);

    // Outside RECV wr_ptr equals cmt_ptr, so every sop beat starts from cmt_ptr.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        cmt_ptr_d = cmt_ptr_q;
        len_d     = len_q;
        we        = 1'b0;
        waddr     = wr_ptr_q[AW-1:0];
        inc_pkt   = 1'b0;
        inc_drop  = 1'b0;
        inc_err   = 1'b0;
        if (snk_valid) begin
            if (snk_startofpacket) begin
                inc_err  = (state_q == S_RECV);
                wr_ptr_d = cmt_ptr_q;
                if (full_cmt) begin
                    inc_drop = 1'b1;
                    state_d  = snk_endofpacket ? S_IDLE : S_DROP;
                end else begin
                    we       = 1'b1;
                    waddr    = cmt_ptr_q[AW-1:0];
                    wr_ptr_d = cmt_ptr_q + PW'(1);
                    len_d    = LW'(1);
                    if (snk_endofpacket) begin
                        cmt_ptr_d = cmt_ptr_q + PW'(1);
                        inc_pkt   = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        state_d   = S_RECV;
                    end
                end
            end else begin
                case (state_q)
                    S_IDLE: inc_err = 1'b1;
                    S_RECV: begin
                        if (full_wr || (len_q >= LW'(MAX_PKT))) begin
                            wr_ptr_d = cmt_ptr_q;
                            inc_drop = 1'b1;
                            state_d  = S_DROP;
                        end else begin
                            we       = 1'b1;
                            wr_ptr_d = wr_ptr_q + PW'(1);
                            len_d    = len_q + LW'(1);
                            if (snk_endofpacket) begin
                                cmt_ptr_d = wr_ptr_q + PW'(1);
                                inc_pkt   = 1'b1;
                                state_d   = S_IDLE;
                            end
                        end
                    end
                    S_DROP: if (snk_endofpacket) state_d = S_IDLE;
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_dsp_clk or posedge reset_dsp_reset) begin
        if (reset_dsp_reset) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            cmt_ptr_q <= '0;
            len_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            cmt_ptr_q <= cmt_ptr_d;
            len_q     <= len_d;
            irq_q     <= inc_drop;
        end
    end

    always_ff @(posedge clk_dsp_clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read side sees commits one cycle late, giving the two-edge eop-to-valid latency.
    logic          load;
    logic [EW-1:0] rd_word;
    logic          out_valid_q;
    logic [EW-1:0] out_word_q;

    assign rd_word = mem[rd_ptr_q[AW-1:0]];
    assign load    = (rd_ptr_q != cmt_vis_q) && (!out_valid_q || src_ready);

    always_ff @(posedge clk_dsp_clk or posedge reset_dsp_reset) begin
        if (reset_dsp_reset) begin
            cmt_vis_q   <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
        end else begin
            cmt_vis_q <= cmt_ptr_q;
            if (load) begin
                out_word_q  <= rd_word;
                out_valid_q <= 1'b1;
                rd_ptr_q    <= rd_ptr_q + PW'(1);
            end else if (src_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign src_valid         = out_valid_q;
    assign src_data          = out_word_q[DATA_W-1:0];
    assign src_channel       = out_word_q[DATA_W +: CH_W];
    assign src_startofpacket = out_word_q[EW-2];
    assign src_endofpacket   = out_word_q[EW-1];
    assign overflow_irq      = irq_q;

`ifdef COUPLING_PKT_RX_STATS_EN
    logic [31:0] pkt_q;
    logic [15:0] drop_q, err_q;

    always_ff @(posedge clk_dsp_clk or posedge reset_dsp_reset) begin
        if (reset_dsp_reset) begin
            pkt_q  <= '0;
            drop_q <= '0;
            err_q  <= '0;
        end else if (count_clear) begin
            pkt_q  <= '0;
            drop_q <= '0;
            err_q  <= '0;
        end else begin
            if (inc_pkt && !(&pkt_q))   pkt_q  <= pkt_q + 32'd1;
            if (inc_drop && !(&drop_q)) drop_q <= drop_q + 16'd1;
            if (inc_err && !(&err_q))   err_q  <= err_q + 16'd1;
        end
    end

    assign pkt_count  = pkt_q;
    assign drop_count = drop_q;
    assign err_count  = err_q;
`else
    logic unused_stats;
    assign unused_stats = &{1'b0, count_clear, inc_pkt, inc_err};
    assign pkt_count    = '0;
    assign drop_count   = '0;
    assign err_count    = '0;
`endif

endmodule

// File: tb/tb_coupling_avst_pkt_rx.sv
// tb/tb_coupling_avst_pkt_rx.sv - randomized and directed bench for coupling_avst_pkt_rx against a queue-based packet model
module tb_coupling_avst_pkt_rx;
    localparam int DEPTH   = 16;
    localparam int MAX_PKT = 12;
`ifdef COUPLING_PKT_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        snk_valid = 1'b0, snk_sop = 1'b0, snk_eop = 1'b0;
    logic [31:0] snk_data = '0;
    logic [15:0] snk_ch = '0;
    logic        src_valid, src_ready, src_sop, src_eop;
    logic [31:0] src_data;
    logic [15:0] src_ch;
    logic        count_clear = 1'b0;
    logic [31:0] pkt_count;
    logic [15:0] drop_count, err_count;
    logic        overflow_irq;
    logic        ready_man = 1'b0, tog_en = 1'b0, tog = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) begin #1 tog = ~tog; end
    assign src_ready = tog_en ? tog : ready_man;

    coupling_avst_pkt_rx #(.DATA_W(32), .CH_W(16), .DEPTH(DEPTH), .MAX_PKT(MAX_PKT)) dut (
        .clk_dsp_clk(clk), .reset_dsp_reset(rst),
        .snk_valid(snk_valid), .snk_data(snk_data), .snk_channel(snk_ch),
        .snk_startofpacket(snk_sop), .snk_endofpacket(snk_eop),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .src_channel(src_ch),
        .src_startofpacket(src_sop), .src_endofpacket(src_eop),
        .count_clear(count_clear), .pkt_count(pkt_count), .drop_count(drop_count),
        .err_count(err_count), .overflow_irq(overflow_irq));

    int npass = 0, ntot = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Model: committed words wait in cq with the edge they were committed on; part is the open packet.
    typedef struct { logic [49:0] w; int cyc; } ent_t;
    ent_t        cq[$];
    logic [49:0] part[$];
    ent_t        tmp_e;
    int          mode = 0;          // 0 idle, 1 receiving, 2 discarding
    int          ecnt = 0;
    logic        mv = 1'b0;
    logic [49:0] mword = '0;
    logic [31:0] m_pkt = '0;
    logic [15:0] m_drop = '0, m_err = '0;
    logic        m_irq = 1'b0;

    always @(posedge clk) begin
        logic ld, pk, dr, er;
        logic [49:0] w;
        int occ;
        ecnt++;
        if (rst) begin
            cq.delete(); part.delete();
            mode = 0; mv = 1'b0; mword = '0; m_irq = 1'b0;
            m_pkt = '0; m_drop = '0; m_err = '0;
        end else begin
            pk = 0; dr = 0; er = 0;
            w   = {snk_eop, snk_sop, snk_ch, snk_data};
            occ = cq.size() + part.size();
            ld  = (!mv || src_ready) && cq.size() > 0 && (cq[0].cyc + 2 <= ecnt);
            if (snk_valid) begin
                if (snk_sop) begin
                    if (mode == 1) er = 1;
                    part.delete();
                    if (cq.size() >= DEPTH) begin
                        dr = 1; mode = snk_eop ? 0 : 2;
                    end else if (snk_eop) begin
                        tmp_e.w = w; tmp_e.cyc = ecnt; cq.push_back(tmp_e); pk = 1; mode = 0;
                    end else begin
                        part.push_back(w); mode = 1;
                    end
                end else if (mode == 0) begin
                    er = 1;
                end else if (mode == 1) begin
                    if (occ >= DEPTH || part.size() >= MAX_PKT) begin
                        part.delete(); dr = 1; mode = 2;
                    end else begin
                        part.push_back(w);
                        if (snk_eop) begin
                            foreach (part[i]) begin tmp_e.w = part[i]; tmp_e.cyc = ecnt; cq.push_back(tmp_e); end
                            part.delete(); pk = 1; mode = 0;
                        end
                    end
                end else if (snk_eop) begin
                    mode = 0;
                end
            end
            if (ld) begin mword = cq[0].w; cq.pop_front(); mv = 1'b1; end
            else if (src_ready) mv = 1'b0;
            m_irq = dr;
            if (count_clear) begin
                m_pkt = '0; m_drop = '0; m_err = '0;
            end else begin
                if (pk && m_pkt != 32'hffff_ffff) m_pkt++;
                if (dr && m_drop != 16'hffff) m_drop++;
                if (er && m_err != 16'hffff) m_err++;
            end
        end
    end

    logic [49:0] got[$];
    int vcnt = 0, icnt = 0, first_edge = -1;
    always @(negedge clk) begin
        if (!rst) begin
            chk("src_valid", {63'd0, src_valid}, {63'd0, mv});
            if (mv) chk("src_word", {14'd0, src_eop, src_sop, src_ch, src_data}, {14'd0, mword});
            chk("overflow_irq", {63'd0, overflow_irq}, {63'd0, m_irq});
            chk("pkt_count", {32'd0, pkt_count}, STATS ? {32'd0, m_pkt} : 64'd0);
            chk("drop_count", {48'd0, drop_count}, STATS ? {48'd0, m_drop} : 64'd0);
            chk("err_count", {48'd0, err_count}, STATS ? {48'd0, m_err} : 64'd0);
            if (src_valid && src_ready) got.push_back({src_eop, src_sop, src_ch, src_data});
            if (src_valid) vcnt++;
            if (overflow_irq) icnt++;
            if (src_valid && first_edge < 0) first_edge = ecnt;
        end
    end

    task automatic beat(input logic v, input logic s, input logic e, input logic [15:0] ch, input logic [31:0] d);
        snk_valid = v; snk_sop = s; snk_eop = e; snk_ch = ch; snk_data = d;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1; snk_valid = 1'b0; tog_en = 1'b0; count_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        got.delete(); vcnt = 0; icnt = 0; first_edge = -1;
    endtask

    function automatic logic [49:0] got_at(input int i);
        return (i < got.size()) ? got[i] : 50'h3_ffff_ffff_ffff;
    endfunction

    initial begin
        int eop_edge;
        int bias[8] = '{90, 20, 60, 5, 100, 40, 75, 0};
        @(negedge clk);
        chk("reset_valid", {63'd0, src_valid}, 64'd0);
        chk("reset_word", {14'd0, src_eop, src_sop, src_ch, src_data}, 64'd0);
        chk("reset_irq", {63'd0, overflow_irq}, 64'd0);
        chk("reset_counts", {pkt_count, drop_count, err_count}, 64'd0);
        do_reset();

        // 8-word packet on channel 3, latency and framing
        ready_man = 1'b1;
        for (int i = 0; i < 8; i++) beat(1'b1, i == 0, i == 7, 16'h0003, 32'h100 + i);
        eop_edge = ecnt;
        idle(12);
        chk("t1_count", got.size(), 8);
        chk("t1_latency", first_edge - eop_edge, 2);
        chk("t1_first", got_at(0), {2'b01, 16'h0003, 32'h100});
        chk("t1_last", got_at(7), {2'b10, 16'h0003, 32'h107});
        chk("t1_pkt", pkt_count, STATS ? 1 : 0);

        // 20-word packet with no drain is dropped, then a 4-word packet passes
        do_reset();
        ready_man = 1'b0;
        for (int i = 0; i < 20; i++) beat(1'b1, i == 0, i == 19, 16'h0001, 32'h200 + i);
        idle(4);
        chk("t2_drop", drop_count, STATS ? 1 : 0);
        chk("t2_irq_pulses", icnt, 1);
        chk("t2_no_valid", vcnt, 0);
        ready_man = 1'b1;
        for (int i = 0; i < 4; i++) beat(1'b1, i == 0, i == 3, 16'h0002, 32'h300 + i);
        idle(8);
        chk("t2_count", got.size(), 4);
        chk("t2_first", got_at(0), {2'b01, 16'h0002, 32'h300});
        chk("t2_last", got_at(3), {2'b10, 16'h0002, 32'h303});

        // truncated packet A then complete packet B
        do_reset();
        for (int i = 0; i < 3; i++) beat(1'b1, i == 0, 1'b0, 16'h000a, 32'h400 + i);
        for (int i = 0; i < 5; i++) beat(1'b1, i == 0, i == 4, 16'h000b, 32'h410 + i);
        idle(8);
        chk("t3_err", err_count, STATS ? 1 : 0);
        chk("t3_pkt", pkt_count, STATS ? 1 : 0);
        chk("t3_count", got.size(), 5);
        chk("t3_first", got_at(0), {2'b01, 16'h000b, 32'h410});

        // stray beat in idle, then single-beat packet
        do_reset();
        beat(1'b1, 1'b0, 1'b0, 16'h0005, 32'hdead);
        idle(5);
        chk("t4_err", err_count, STATS ? 1 : 0);
        chk("t4_no_valid", vcnt, 0);
        beat(1'b1, 1'b1, 1'b1, 16'h0006, 32'hbeef);
        idle(6);
        chk("t4_single", got_at(0), {2'b11, 16'h0006, 32'hbeef});
        chk("t4_count", got.size(), 1);

        // back-to-back packets with toggling ready
        do_reset();
        tog_en = 1'b1;
        for (int i = 0; i < 8; i++) beat(1'b1, (i % 4) == 0, (i % 4) == 3, 16'h0007, 32'h500 + i);
        idle(24);
        tog_en = 1'b0;
        chk("t5_count", got.size(), 8);
        for (int i = 0; i < 8; i++) chk("t5_order", got_at(i)[31:0], 32'h500 + i);
        chk("t5_pkt", pkt_count, STATS ? 2 : 0);

        // reset with committed words buffered and a packet in flight
        do_reset();
        ready_man = 1'b0;
        for (int i = 0; i < 3; i++) beat(1'b1, i == 0, i == 2, 16'h0008, 32'h600 + i);
        beat(1'b1, 1'b1, 1'b0, 16'h0008, 32'h610);
        beat(1'b1, 1'b0, 1'b0, 16'h0008, 32'h611);
        chk("t6_valid_before", {63'd0, src_valid}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_valid_in_reset", {63'd0, src_valid}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        got.delete(); vcnt = 0;
        ready_man = 1'b1;
        idle(10);
        chk("t6_empty", vcnt, 0);
        chk("t6_counts", {pkt_count, drop_count, err_count}, 64'd0);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3200; i++) begin
            ready_man   = ($urandom_range(0, 99) < bias[i / 400]);
            count_clear = ($urandom_range(0, 299) == 0);
            beat($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 20,
                 16'($urandom), $urandom);
        end
        count_clear = 1'b0;
        ready_man = 1'b1;
        idle(60);
        chk("drain_empty", {63'd0, src_valid}, 64'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", npass, ntot);
        $fatal(1);
    end
endmodule
